// File: rtl/acs_array.sv
// Add-compare-select array for a rate-1/2 Viterbi decoder: every trellis state
// is updated in parallel once per accepted symbol, with survivor decisions and the best metric.
module acs_array #(
  parameter int             K       = 7,
  parameter int             PM_W    = 11,
  parameter int             BM_W    = 6,
  parameter logic [K-1:0]   G0      = 7'o171,
  parameter logic [K-1:0]   G1      = 7'o133,
  parameter int             INIT_PM = 2**(PM_W-3)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    bm_valid,
  input  logic [4*BM_W-1:0]       bm_in,
  output logic                    bm_ready,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [(1<<(K-1))-1:0]   dec_bits,
  output logic [K-2:0]            best_state,
  output logic [PM_W-1:0]         best_pm,
  output logic                    norm_flag
);

  localparam int NS = 1 << (K-1);

  logic [PM_W-1:0] pm [NS];

  logic [PM_W-1:0] cand0_p0 [NS];
  logic [PM_W-1:0] cand1_p0 [NS];
  logic [PM_W-1:0] sel_p0   [NS];
  logic [PM_W-1:0] norm_p0  [NS];
  logic [NS-1:0]   dec_p0;
  logic            all_msb_p0;
  logic [K-2:0]    best_state_p0;
  logic [PM_W-1:0] best_pm_p0;
  logic            accept;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                               input logic [BM_W-1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W+1-BM_W){1'b0}}, b};
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  function automatic logic [PM_W-1:0] start_pm(input int s);
    return (s == 0) ? '0 : PM_W'(INIT_PM);
  endfunction

  function automatic logic [K-2:0] pred(input logic [K-2:0] ns, input logic b);
    return {ns[K-3:0], b};
  endfunction

  // The encoder register holds the new input bit on top of the predecessor state.
  function automatic logic [BM_W-1:0] branch_metric(input logic [K-2:0] ns,
                                                    input logic b,
                                                    input logic [4*BM_W-1:0] bms);
    logic [K-1:0] r;
    logic [1:0]   code;
    r    = {ns[K-2], pred(ns, b)};
    code = {^(r & G0), ^(r & G1)};
    return bms[int'(code)*BM_W +: BM_W];
  endfunction

  assign bm_ready = !start && (!dec_valid || dec_ready);
  assign accept   = bm_valid && bm_ready;

  // Stage p0: add, compare-select, normalise, minimum search
  always_comb begin
    dec_p0        = '0;
    all_msb_p0    = 1'b1;
    best_state_p0 = '0;
    best_pm_p0    = '0;
    for (int s = 0; s < NS; s++) begin
      cand0_p0[s] = sat_add(pm[pred((K-1)'(s), 1'b0)], branch_metric((K-1)'(s), 1'b0, bm_in));
      cand1_p0[s] = sat_add(pm[pred((K-1)'(s), 1'b1)], branch_metric((K-1)'(s), 1'b1, bm_in));
      if (cand0_p0[s] < cand1_p0[s]) begin
        sel_p0[s] = cand0_p0[s];
      end else begin
        sel_p0[s] = cand1_p0[s];
        dec_p0[s] = 1'b1;
      end
      all_msb_p0 = all_msb_p0 & sel_p0[s][PM_W-1];
    end
    for (int s = 0; s < NS; s++) begin
      norm_p0[s] = all_msb_p0 ? {1'b0, sel_p0[s][PM_W-2:0]} : sel_p0[s];
    end
    best_pm_p0 = norm_p0[0];
    for (int s = 1; s < NS; s++) begin
      if (norm_p0[s] < best_pm_p0) begin
        best_pm_p0    = norm_p0[s];
        best_state_p0 = (K-1)'(s);
      end
    end
  end

  // Stage p1: metric bank and decision output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) pm[s] <= start_pm(s);
      dec_valid  <= 1'b0;
      dec_bits   <= '0;
      best_state <= '0;
      best_pm    <= '0;
      norm_flag  <= 1'b0;
    end else if (start) begin
      for (int s = 0; s < NS; s++) pm[s] <= start_pm(s);
      dec_valid <= 1'b0;
    end else if (accept) begin
      for (int s = 0; s < NS; s++) pm[s] <= norm_p0[s];
      dec_valid  <= 1'b1;
      dec_bits   <= dec_p0;
      best_state <= best_state_p0;
      best_pm    <= best_pm_p0;
      norm_flag  <= all_msb_p0;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule
